// File: rtl/prbs_pkg.sv
// Shared constants, FSM state type and saturating-increment helpers for the PRBS31 checker.
package prbs_pkg;

  localparam int unsigned PRBS_LEN = 31;
  localparam int unsigned TAP_A    = 31;
  localparam int unsigned TAP_B    = 28;

  localparam int unsigned CNT_W    = 64;
  localparam int unsigned LOSS_W   = 16;
  localparam int unsigned FILL_W   = $clog2(PRBS_LEN);

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLocked
  } chk_state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
    return (&v) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/prbs31_predictor.sv
// 31-bit PRBS31 history register with tap XOR prediction.
// Loads the received bit while acquiring and its own prediction while locked.
module prbs31_predictor
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_bit,
  input  logic use_pred,
  output logic pred_bit
);

  // hist_q[k-1] holds the bit received k bits ago
  logic [PRBS_LEN-1:0] hist_q;
  logic                load_bit;

  assign pred_bit = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
  assign load_bit = use_pred ? pred_bit : rx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[PRBS_LEN-2:0], load_bit};
    end
  end

endmodule

// File: rtl/prbs31_serial_rx_checker.sv
// PRBS31 serial receive checker: hunt/check/locked acquisition FSM with
// windowed loss-of-lock detection and saturating error/bit/loss statistics.
module prbs31_serial_rx_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_BITS = 64,
  parameter int unsigned WIN_BITS  = 1024,
  parameter int unsigned LOSS_ERRS = 8
) (
  input  logic              CLKBit,
  input  logic              RSTn,
  input  logic              DataIn,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  Error_bit_Count,
  output logic [CNT_W-1:0]  checked_bit_count,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int unsigned GoodW = $clog2(LOCK_BITS + 1);
  localparam int unsigned WinW  = (WIN_BITS > 1) ? $clog2(WIN_BITS) : 1;
  localparam int unsigned ErrW  = $clog2(LOSS_ERRS + 1);

  chk_state_e        state_q;
  logic [FILL_W-1:0] fill_q;
  logic [GoodW-1:0]  good_q;
  logic [WinW-1:0]   win_cnt_q;
  logic [ErrW-1:0]   win_err_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [LOSS_W-1:0] loss_cnt_q;

  logic pred_bit;
  logic bit_err;
  logic fill_done;
  logic lock_hit;
  logic win_last;
  logic loss_hit;

  prbs31_predictor u_predictor (
    .clk      (CLKBit),
    .rst_n    (RSTn),
    .rx_bit   (DataIn),
    .use_pred (state_q == StLocked),
    .pred_bit (pred_bit)
  );

  always_comb begin
    bit_err   = DataIn ^ pred_bit;
    fill_done = (fill_q == FILL_W'(PRBS_LEN - 1));
    lock_hit  = !bit_err && (good_q == GoodW'(LOCK_BITS - 1));
    win_last  = (win_cnt_q == WinW'(WIN_BITS - 1));
    // The current bit's error is included so the threshold trips on the same edge
    loss_hit  = bit_err && (win_err_q == ErrW'(LOSS_ERRS - 1));
  end

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StHunt;
      fill_q      <= '0;
      good_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (fill_done) begin
            state_q <= StCheck;
            fill_q  <= '0;
            good_q  <= '0;
          end else begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        StCheck: begin
          if (bit_err) begin
            good_q <= '0;
          end else if (lock_hit) begin
            state_q   <= StLocked;
            locked_q  <= 1'b1;
            good_q    <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
          end else begin
            good_q <= good_q + GoodW'(1);
          end
        end
        StLocked: begin
          bit_cnt_q <= sat_inc_cnt(bit_cnt_q);
          if (bit_err) begin
            err_cnt_q   <= sat_inc_cnt(err_cnt_q);
            err_pulse_q <= 1'b1;
          end
          if (loss_hit) begin
            state_q    <= StHunt;
            locked_q   <= 1'b0;
            fill_q     <= '0;
            good_q     <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            loss_cnt_q <= sat_inc_loss(loss_cnt_q);
          end else if (win_last) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + WinW'(1);
            if (bit_err) begin
              win_err_q <= win_err_q + ErrW'(1);
            end
          end
        end
        default: begin
          state_q  <= StHunt;
          locked_q <= 1'b0;
          fill_q   <= '0;
        end
      endcase
      if (clear) begin
        err_cnt_q  <= '0;
        bit_cnt_q  <= '0;
        loss_cnt_q <= '0;
      end
    end
  end

  assign locked            = locked_q;
  assign err_pulse         = err_pulse_q;
  assign Error_bit_Count   = err_cnt_q;
  assign checked_bit_count = bit_cnt_q;
  assign lock_loss_count   = loss_cnt_q;

endmodule

// File: tb/tb_prbs31_serial_rx_checker.sv
// Directed and randomized bench for the PRBS31 checker against a bit-level
// behavioural model of acquisition, windowed loss of lock and statistics.
module tb_prbs31_serial_rx_checker;

  localparam int unsigned LockBits = 64;
  localparam int unsigned WinBits  = 1024;
  localparam int unsigned LossErrs = 8;

  logic        CLKBit = 1'b0;
  logic        RSTn;
  logic        DataIn;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [63:0] Error_bit_Count;
  logic [63:0] checked_bit_count;
  logic [15:0] lock_loss_count;

  int n_cmp = 0;
  int n_bad = 0;

  prbs31_serial_rx_checker #(
    .LOCK_BITS (LockBits),
    .WIN_BITS  (WinBits),
    .LOSS_ERRS (LossErrs)
  ) dut (
    .CLKBit            (CLKBit),
    .RSTn              (RSTn),
    .DataIn            (DataIn),
    .clear             (clear),
    .locked            (locked),
    .err_pulse         (err_pulse),
    .Error_bit_Count   (Error_bit_Count),
    .checked_bit_count (checked_bit_count),
    .lock_loss_count   (lock_loss_count)
  );

  always #5 CLKBit = ~CLKBit;

  // Transmit-side PRBS31 source, seeded all-ones
  bit gq[$];
  // Reference: the last 31 bits the checker should be predicting from, oldest first
  bit mh[$];
  int m_mode;  // 0 acquiring fill, 1 counting good bits, 2 in lock
  int m_fill, m_good, m_wpos, m_werr;
  longint unsigned m_errs, m_bits;
  int unsigned m_loss;
  bit m_pulse;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit gen_bit();
    bit b = gq[0];
    gq.push_back(gq[0] ^ gq[3]);
    void'(gq.pop_front());
    return b;
  endfunction

  task automatic model_reset();
    mh = {};
    repeat (31) mh.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_good = 0; m_wpos = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_loss = 0; m_pulse = 0;
  endtask

  task automatic model(input bit rx, input bit clr);
    bit pred = mh[0] ^ mh[3];
    bit mis  = rx ^ pred;
    m_pulse = 0;
    if (m_mode == 0) begin
      mh.push_back(rx);
      m_fill++;
      if (m_fill == 31) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      mh.push_back(rx);
      m_good = mis ? 0 : m_good + 1;
      if (m_good == LockBits) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
    end else begin
      mh.push_back(pred);
      if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits++;
      m_wpos++;
      if (mis) begin
        if (m_errs != 64'hFFFF_FFFF_FFFF_FFFF) m_errs++;
        m_werr++;
        m_pulse = 1;
      end
      if (m_werr == LossErrs) begin
        m_mode = 0; m_fill = 0; m_good = 0; m_wpos = 0; m_werr = 0;
        if (m_loss != 32'hFFFF) m_loss++;
      end else if (m_wpos == WinBits) begin
        m_wpos = 0; m_werr = 0;
      end
    end
    void'(mh.pop_front());
    if (clr) begin m_errs = 0; m_bits = 0; m_loss = 0; end
  endtask

  task automatic step(input bit flip, input bit clr);
    bit rx = gen_bit() ^ flip;
    DataIn = rx;
    clear  = clr;
    model(rx, clr);
    @(posedge CLKBit);
    #1;
    chk("m_locked", locked, 64'(m_mode == 2));
    chk("m_err_pulse", err_pulse, 64'(m_pulse));
    chk("m_err_count", Error_bit_Count, m_errs);
    chk("m_bit_count", checked_bit_count, m_bits);
    chk("m_loss_count", lock_loss_count, 64'(m_loss));
  endtask

  task automatic relock(input string tag);
    int n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (!locked && n < 300);
    chk(tag, n, 95);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_pulse"}, err_pulse, 0);
    chk({tag, "_errs"}, Error_bit_Count, 0);
    chk({tag, "_bits"}, checked_bit_count, 0);
    chk({tag, "_loss"}, lock_loss_count, 0);
  endtask

  task automatic async_reset();
    #2 RSTn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge CLKBit);
    #1 RSTn = 1'b1;
    model_reset();
  endtask

  initial begin
    bit fl[WinBits];
    bit fell;
    int placed;
    int r;

    RSTn = 1'b0; DataIn = 1'b0; clear = 1'b0;
    repeat (31) gq.push_back(1'b1);
    model_reset();
    repeat (2) @(posedge CLKBit);
    #1 chk_all_zero("reset");
    RSTn = 1'b1;

    // Clean acquisition from the first transmitted bit
    relock("lock_latency");
    chk("clean_errs", Error_bit_Count, 0);

    // Single flipped bit while locked
    step(1'b1, 1'b0);
    chk("single_pulse", err_pulse, 1);
    chk("single_errs", Error_bit_Count, 1);
    chk("single_locked", locked, 1);
    step(1'b0, 1'b0);
    chk("single_pulse_end", err_pulse, 0);
    chk("single_errs_hold", Error_bit_Count, 1);

    // clear coincident with an error, then counting resumes
    step(1'b1, 1'b1);
    chk("clr_pulse", err_pulse, 1);
    chk("clr_errs", Error_bit_Count, 0);
    step(1'b1, 1'b0);
    chk("clr_resume", Error_bit_Count, 1);

    // Async reset while locked, then eight errors in one window
    async_reset();
    relock("relock_after_rst");
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(1, 100)) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      if (k < 7) chk("loss_still_locked", locked, 1);
    end
    chk("loss_locked_fell", locked, 0);
    chk("loss_count", lock_loss_count, 1);
    chk("loss_errs", Error_bit_Count, 8);
    relock("relock_after_loss");

    // Seven errors per window for ten windows never drops lock
    async_reset();
    relock("relock_windows");
    fell = 1'b0;
    for (int w = 0; w < 10; w++) begin
      foreach (fl[i]) fl[i] = 1'b0;
      placed = 0;
      while (placed < 7) begin
        r = int'($urandom_range(0, WinBits - 1));
        if (!fl[r]) begin fl[r] = 1'b1; placed++; end
      end
      for (int p = 0; p < int'(WinBits); p++) begin
        step(fl[p], 1'b0);
        if (!locked) fell = 1'b1;
      end
    end
    chk("win_never_fell", fell, 0);
    chk("win_errs", Error_bit_Count, 70);
    chk("win_bits", checked_bit_count, 10240);
    chk("win_loss", lock_loss_count, 0);

    // Random error and clear traffic against the model
    repeat (3000) step($urandom_range(0, 149) == 0, $urandom_range(0, 399) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
